// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the decode stage and pipeline_hazard_ctrl.
// The master side presents ID/EX hazard information and consumes the
// stall/flush/bubble controls; the slave side is the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    // Hazard information from ID and EX
    logic             id_valid_i;
    logic [6:0]       id_opcode_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             ex_mem_read_i;
    logic [4:0]       ex_rd_i;
    logic             branch_taken_i;
    logic             dmem_busy_i;

    // Pipeline control back to PC, IF/ID and ID/EX
    logic             pc_stall_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_valid_i, id_opcode_i, id_rs1_i, id_rs2_i,
        output ex_mem_read_i, ex_rd_i, branch_taken_i, dmem_busy_i,
        input  pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
        input  state_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_opcode_i, id_rs1_i, id_rs2_i,
        input  ex_mem_read_i, ex_rd_i, branch_taken_i, dmem_busy_i,
        output pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
        output state_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: decode-stage sequencer for load-use stalls,
// taken-branch flushes and data-memory freezes.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is
// defined; otherwise stall_cnt_o/flush_cnt_o are tied to zero.
// While frozen, the state that would have followed (and the remaining
// flush length) is parked; on the cycle busy drops, that parked state is
// evaluated directly so no freeze cycle is wasted and no flush cycle is lost.
module pipeline_hazard_ctrl #(
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_W          = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_FREEZE     = 2'd3
    } state_e;

    // Flush cycles remaining after the branch cycle itself
    localparam logic [2:0] PEN_RELOAD = 3'(BRANCH_PENALTY - 1);
    // With a penalty of one, the branch cycle is the whole flush
    localparam logic       PEN_SINGLE = (BRANCH_PENALTY == 1) ? 1'b1 : 1'b0;

    // Opcodes that read rs2: R-type, store, conditional branch
    function automatic logic uses_rs2(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
            default:                            uses_rs2 = 1'b0;
        endcase
    endfunction

    // Opcodes that read rs1: the rs2 users plus OP-IMM, load, JALR
    function automatic logic uses_rs1(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0100011, 7'b1100011,
            7'b0010011, 7'b0000011, 7'b1100111: uses_rs1 = 1'b1;
            default:                            uses_rs1 = 1'b0;
        endcase
    endfunction

    state_e     state_q, state_d;
    state_e     saved_state_q, saved_state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [2:0] saved_cnt_q, saved_cnt_d;

    state_e     eff_state_s;
    logic [2:0] eff_cnt_s;
    state_e     nb_state_s;
    logic [2:0] nb_cnt_s;
    logic       load_use_s;

    logic       pc_stall_s;
    logic       ifid_stall_s;
    logic       ifid_flush_s;
    logic       idex_bubble_s;

    // Load-use detection: EX load writes a register that ID actually reads
    always_comb begin
        load_use_s = 1'b0;
        if (hz.id_valid_i && hz.ex_mem_read_i && (hz.ex_rd_i != 5'd0)) begin
            load_use_s = (uses_rs1(hz.id_opcode_i) && (hz.id_rs1_i == hz.ex_rd_i)) ||
                         (uses_rs2(hz.id_opcode_i) && (hz.id_rs2_i == hz.ex_rd_i));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // Effective state: the parked state takes over on the cycle busy drops
    always_comb begin
        eff_state_s = state_q;
        eff_cnt_s   = cnt_q;
        if ((state_q == ST_FREEZE) && !hz.dmem_busy_i) begin
            eff_state_s = saved_state_q;
            eff_cnt_s   = saved_cnt_q;
        end else begin
            eff_state_s = state_q;
            eff_cnt_s   = cnt_q;
        end
    end

    // Next state ignoring dmem_busy_i (branch beats load-use)
    always_comb begin
        nb_state_s = ST_RUN;
        nb_cnt_s   = 3'd0;
        case (eff_state_s)
            ST_RUN, ST_LOAD_STALL: begin
                if (hz.branch_taken_i) begin
                    nb_state_s = PEN_SINGLE ? ST_RUN : ST_FLUSH;
                    nb_cnt_s   = PEN_RELOAD;
                end else if (load_use_s && (eff_state_s == ST_RUN)) begin
                    nb_state_s = ST_LOAD_STALL;
                    nb_cnt_s   = 3'd0;
                end else begin
                    nb_state_s = ST_RUN;
                    nb_cnt_s   = 3'd0;
                end
            end
            ST_FLUSH: begin
                if (hz.branch_taken_i) begin
                    nb_state_s = PEN_SINGLE ? ST_RUN : ST_FLUSH;
                    nb_cnt_s   = PEN_RELOAD;
                end else if (eff_cnt_s <= 3'd1) begin
                    nb_state_s = ST_RUN;
                    nb_cnt_s   = 3'd0;
                end else begin
                    nb_state_s = ST_FLUSH;
                    nb_cnt_s   = eff_cnt_s - 3'd1;
                end
            end
            ST_FREEZE: begin
                nb_state_s = ST_FREEZE;
                nb_cnt_s   = eff_cnt_s;
            end
            default: begin
                nb_state_s = ST_RUN;
                nb_cnt_s   = 3'd0;
            end
        endcase
    end

    // Final next state: busy overrides everything and parks the resume point
    always_comb begin
        state_d       = nb_state_s;
        cnt_d         = nb_cnt_s;
        saved_state_d = saved_state_q;
        saved_cnt_d   = saved_cnt_q;
        if (hz.dmem_busy_i) begin
            state_d = ST_FREEZE;
            cnt_d   = cnt_q;
            if (eff_state_s == ST_FREEZE) begin
                saved_state_d = saved_state_q;
                saved_cnt_d   = saved_cnt_q;
            end else if ((eff_state_s == ST_FLUSH) && !hz.branch_taken_i) begin
                // A frozen flush keeps its remaining length untouched
                saved_state_d = ST_FLUSH;
                saved_cnt_d   = eff_cnt_s;
            end else begin
                saved_state_d = nb_state_s;
                saved_cnt_d   = nb_cnt_s;
            end
        end else begin
            state_d       = nb_state_s;
            cnt_d         = nb_cnt_s;
            saved_state_d = saved_state_q;
            saved_cnt_d   = saved_cnt_q;
        end
    end

    // FSM, flush counter and parked resume point
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_RUN;
            cnt_q         <= 3'd0;
            saved_state_q <= ST_RUN;
            saved_cnt_q   <= 3'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            saved_state_q <= saved_state_d;
            saved_cnt_q   <= saved_cnt_d;
        end
    end

    // Control decode: freeze > flush > load-use stall > pass
    always_comb begin
        pc_stall_s    = 1'b0;
        ifid_stall_s  = 1'b0;
        ifid_flush_s  = 1'b0;
        idex_bubble_s = 1'b0;
        if (hz.dmem_busy_i) begin
            pc_stall_s   = 1'b1;
            ifid_stall_s = 1'b1;
        end else if (hz.branch_taken_i || (eff_state_s == ST_FLUSH)) begin
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else if (load_use_s &&
                     ((eff_state_s == ST_RUN) || (eff_state_s == ST_LOAD_STALL))) begin
            pc_stall_s    = 1'b1;
            ifid_stall_s  = 1'b1;
            idex_bubble_s = 1'b1;
        end else begin
            pc_stall_s    = 1'b0;
            ifid_stall_s  = 1'b0;
            ifid_flush_s  = 1'b0;
            idex_bubble_s = 1'b0;
        end
    end

    assign hz.pc_stall_o    = pc_stall_s;
    assign hz.ifid_stall_o  = ifid_stall_s;
    assign hz.ifid_flush_o  = ifid_flush_s;
    assign hz.idex_bubble_o = idex_bubble_s;
    assign hz.state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating increments of the stall and flush cycle counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (ifid_flush_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= {CNT_W{1'b0}};
            flush_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.stall_cnt_o = stall_cnt_q;
    assign hz.flush_cnt_o = flush_cnt_q;
`else
    assign hz.stall_cnt_o = {CNT_W{1'b0}};
    assign hz.flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (BRANCH_PENALTY=2).
// Stimulus drives one cycle at a time just after the rising edge and pushes
// the hand-computed response; a monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_S  = 7'b0100011;

    typedef struct {
        string       name;
        logic [3:0]  outs;   // {pc_stall, ifid_stall, ifid_flush, idex_bubble}
        logic [1:0]  st;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   n_checks;
    int   n_err;
    logic [31:0] sc_m;
    logic [31:0] fc_m;

    pipeline_hazard_ctrl_if #(.CNT_W(32)) hz_if ();

    pipeline_hazard_ctrl #(
        .BRANCH_PENALTY (2),
        .CNT_W          (32)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .hz     (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One stimulus cycle plus its expected response
    task automatic cyc(input string nm, input logic v, input logic [6:0] op,
                       input logic [4:0] r1, input logic [4:0] r2, input logic mr,
                       input logic [4:0] rd, input logic br, input logic bz,
                       input logic [3:0] eo, input logic [1:0] es);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                = 1'b1;
        hz_if.id_valid_i     = v;
        hz_if.id_opcode_i    = op;
        hz_if.id_rs1_i       = r1;
        hz_if.id_rs2_i       = r2;
        hz_if.ex_mem_read_i  = mr;
        hz_if.ex_rd_i        = rd;
        hz_if.branch_taken_i = br;
        hz_if.dmem_busy_i    = bz;
        e.name = nm; e.outs = eo; e.st = es; e.sc = sc_m; e.fc = fc_m;
        sb_q.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
        if (eo[3]) sc_m = sc_m + 32'd1;
        if (eo[1]) fc_m = fc_m + 32'd1;
`endif
    endtask

    // Asynchronous reset asserted mid-cycle with idle inputs
    task automatic rst_cyc(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n                = 1'b0;
        hz_if.id_valid_i     = 1'b0;
        hz_if.id_opcode_i    = 7'd0;
        hz_if.id_rs1_i       = 5'd0;
        hz_if.id_rs2_i       = 5'd0;
        hz_if.ex_mem_read_i  = 1'b0;
        hz_if.ex_rd_i        = 5'd0;
        hz_if.branch_taken_i = 1'b0;
        hz_if.dmem_busy_i    = 1'b0;
        sc_m = 32'd0;
        fc_m = 32'd0;
        e.name = nm; e.outs = 4'b0000; e.st = 2'd0; e.sc = 32'd0; e.fc = 32'd0;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the presented controls against the oldest expectation
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [3:0] act;
            e   = sb_q.pop_front();
            act = {hz_if.pc_stall_o, hz_if.ifid_stall_o, hz_if.ifid_flush_o, hz_if.idex_bubble_o};
            n_checks++;
            if ({act, hz_if.state_o} !== {e.outs, e.st}) begin
                n_err++;
                $display("FAIL %s: got ctl=%b state=%0d, expected ctl=%b state=%0d",
                         e.name, act, hz_if.state_o, e.outs, e.st);
            end
            n_checks++;
            if ({hz_if.stall_cnt_o, hz_if.flush_cnt_o} !== {e.sc, e.fc}) begin
                n_err++;
                $display("FAIL %s_cnt: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                         e.name, hz_if.stall_cnt_o, hz_if.flush_cnt_o, e.sc, e.fc);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        sc_m     = 32'd0;
        fc_m     = 32'd0;
        rst_n    = 1'b0;
        hz_if.id_valid_i = 1'b0; hz_if.id_opcode_i = 7'd0; hz_if.id_rs1_i = 5'd0;
        hz_if.id_rs2_i = 5'd0; hz_if.ex_mem_read_i = 1'b0; hz_if.ex_rd_i = 5'd0;
        hz_if.branch_taken_i = 1'b0; hz_if.dmem_busy_i = 1'b0;

        //      name           v     op    rs1   rs2   mr    rd    br    bz    {ps,is,fl,bb} st
        rst_cyc("reset");
        cyc("idle",          1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("lu_add",        1'b1, OP_R, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 4'b1101, 2'd0);
        cyc("lu_release",    1'b1, OP_R, 5'd5, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd1);
        cyc("rd_zero",       1'b1, OP_R, 5'd0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("opimm_rs2",     1'b1, OP_I, 5'd6, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("store_rs2",     1'b1, OP_S, 5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 4'b1101, 2'd0);
        cyc("store_release", 1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd1);
        cyc("lu_invalid",    1'b0, OP_R, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("br_pulse",      1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'b0011, 2'd0);
        cyc("br_flush2",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0011, 2'd2);
        cyc("br_done",       1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("frz_br",        1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'b0011, 2'd0);
        cyc("frz_busy1",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 2'd2);
        cyc("frz_busy2",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 2'd3);
        cyc("frz_busy3",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 2'd3);
        cyc("frz_resume",    1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0011, 2'd3);
        cyc("frz_done",      1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("lu_and_br",     1'b1, OP_R, 5'd5, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 4'b0011, 2'd0);
        cyc("lu_in_flush",   1'b1, OP_R, 5'd5, 5'd7, 1'b1, 5'd5, 1'b0, 1'b0, 4'b0011, 2'd2);
        cyc("rebr_first",    1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'b0011, 2'd0);
        cyc("rebr_reload",   1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'b0011, 2'd2);
        cyc("rebr_tail",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0011, 2'd2);
        cyc("rebr_done",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("run_busy",      1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 4'b1100, 2'd0);
        cyc("run_resume",    1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd3);
        cyc("run_after",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("br_pre_rst",    1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 4'b0011, 2'd0);
        rst_cyc("rst_in_flush");
        cyc("post_rst1",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);
        cyc("post_rst2",     1'b0, OP_R, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 4'b0000, 2'd0);

        // Let the monitor drain, bounded
        for (int i = 0; i < 4; i++) begin
            if (sb_q.size() > 0) @(negedge clk);
        end
        #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0 pending", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
